// File: rtl/joker_ep_out_buf.sv
// EP2 OUT packet buffer: stores one host OUT packet, presents it to the command
// consumer and hands ACK/NAK decisions back to the USB packet engine.
module joker_ep_out_buf #(
    parameter int unsigned MAX_PKT  = 512,
    parameter int unsigned IDX_W    = 9,
    parameter int unsigned ACK_HOLD = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    input  logic        rx_err,
    output logic        rx_ack,
    output logic        rx_nak,
    output logic        buf_out_hasdata,
    output logic [9:0]  buf_out_len,
    input  logic [10:0] buf_out_addr,
    output logic [7:0]  buf_out_q,
    input  logic        buf_out_arm,
    output logic        buf_out_arm_ack,
    output logic [7:0]  drop_cnt
);
    typedef enum logic [2:0] {
        StEmpty,
        StRecv,
        StDiscard,
        StFull,
        StAck,
        StRearm
    } state_e;

    localparam int unsigned HoldW = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [IDX_W:0] MaxPtr = MAX_PKT[IDX_W:0];
    localparam logic [HoldW-1:0] HoldLast = HoldW'(ACK_HOLD - 1);

    state_e           state;
    logic [IDX_W:0]   wr_ptr;
    logic [HoldW-1:0] hold_cnt;
    logic [7:0]       ram [MAX_PKT];
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [7:0]       drop_inc;
    logic             nak_hit;
    logic             unused_addr;

    assign drop_inc    = (drop_cnt == 8'hFF) ? drop_cnt : drop_cnt + 8'd1;
    assign nak_hit     = rx_valid & rx_last & ~rx_err;
    assign unused_addr = ^buf_out_addr[10:IDX_W];

    // Bytes past the buffer end and errored bytes never reach the RAM.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = wr_ptr[IDX_W-1:0];
        if (rx_valid && !rx_err) begin
            if (state == StEmpty) begin
                wr_en  = 1'b1;
                wr_idx = '0;
            end else if (state == StRecv && wr_ptr != MaxPtr) begin
                wr_en = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_idx] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_out_q <= '0;
        end else begin
            buf_out_q <= ram[buf_out_addr[IDX_W-1:0]];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= StEmpty;
            wr_ptr          <= '0;
            hold_cnt        <= '0;
            rx_ack          <= 1'b0;
            rx_nak          <= 1'b0;
            buf_out_hasdata <= 1'b0;
            buf_out_len     <= '0;
            buf_out_arm_ack <= 1'b0;
            drop_cnt        <= '0;
        end else begin
            rx_ack <= 1'b0;
            rx_nak <= 1'b0;
            unique case (state)
                StEmpty: begin
                    if (rx_err) begin
                        drop_cnt <= drop_inc;
                    end else if (rx_valid) begin
                        wr_ptr <= {{IDX_W{1'b0}}, 1'b1};
                        if (rx_last) begin
                            buf_out_len     <= 10'd1;
                            buf_out_hasdata <= 1'b1;
                            rx_ack          <= 1'b1;
                            state           <= StFull;
                        end else begin
                            state <= StRecv;
                        end
                    end
                end
                StRecv: begin
                    if (rx_err) begin
                        wr_ptr   <= '0;
                        drop_cnt <= drop_inc;
                        state    <= StEmpty;
                    end else if (rx_valid) begin
                        if (wr_ptr == MaxPtr) begin
                            if (rx_last) begin
                                wr_ptr   <= '0;
                                drop_cnt <= drop_inc;
                                state    <= StEmpty;
                            end else begin
                                state <= StDiscard;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                            if (rx_last) begin
                                buf_out_len     <= 10'(wr_ptr + 1'b1);
                                buf_out_hasdata <= 1'b1;
                                rx_ack          <= 1'b1;
                                state           <= StFull;
                            end
                        end
                    end
                end
                StDiscard: begin
                    if (rx_err || (rx_valid && rx_last)) begin
                        wr_ptr   <= '0;
                        drop_cnt <= drop_inc;
                        state    <= StEmpty;
                    end
                end
                StFull: begin
                    rx_nak <= nak_hit;
                    if (buf_out_arm) begin
                        buf_out_hasdata <= 1'b0;
                        buf_out_arm_ack <= 1'b1;
                        hold_cnt        <= '0;
                        state           <= StAck;
                    end
                end
                StAck: begin
                    rx_nak <= nak_hit;
                    if (hold_cnt == HoldLast) begin
                        buf_out_arm_ack <= 1'b0;
                        state           <= StRearm;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                StRearm: begin
                    rx_nak <= nak_hit;
                    // Consumer must drop arm before the buffer can be refilled.
                    if (!buf_out_arm) begin
                        wr_ptr <= '0;
                        state  <= StEmpty;
                    end
                end
                default: state <= StEmpty;
            endcase
        end
    end
endmodule

// File: tb/tb_joker_ep_out_buf.sv
// Bench for joker_ep_out_buf: directed sequence with random payloads checked
// against a packet-level model of the buffer.
module tb_joker_ep_out_buf;
    localparam int MAX_PKT  = 512;
    localparam int IDX_W    = 9;
    localparam int ACK_HOLD = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_last = 1'b0;
    logic        rx_err = 1'b0;
    logic        rx_ack;
    logic        rx_nak;
    logic        buf_out_hasdata;
    logic [9:0]  buf_out_len;
    logic [10:0] buf_out_addr = '0;
    logic [7:0]  buf_out_q;
    logic        buf_out_arm = 1'b0;
    logic        buf_out_arm_ack;
    logic [7:0]  drop_cnt;

    joker_ep_out_buf #(
        .MAX_PKT  (MAX_PKT),
        .IDX_W    (IDX_W),
        .ACK_HOLD (ACK_HOLD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_valid        (rx_valid),
        .rx_data         (rx_data),
        .rx_last         (rx_last),
        .rx_err          (rx_err),
        .rx_ack          (rx_ack),
        .rx_nak          (rx_nak),
        .buf_out_hasdata (buf_out_hasdata),
        .buf_out_len     (buf_out_len),
        .buf_out_addr    (buf_out_addr),
        .buf_out_q       (buf_out_q),
        .buf_out_arm     (buf_out_arm),
        .buf_out_arm_ack (buf_out_arm_ack),
        .drop_cnt        (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ack_seen = 0;
    int nak_seen = 0;
    int both_seen = 0;
    int arm_ack_seen = 0;

    always @(negedge clk) begin
        if (rx_ack) ack_seen++;
        if (rx_nak) nak_seen++;
        if (rx_ack && rx_nak) both_seen++;
        if (buf_out_arm_ack) arm_ack_seen++;
    end

    // Model: phase 0 = free, 1 = holding a packet, 2 = being released.
    int         m_phase = 0;
    int         m_len = 0;
    int         m_drop = 0;
    logic [7:0] mem [MAX_PKT];
    logic [7:0] tx [1024];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) tx[i] = 8'($urandom);
    endtask

    task automatic send(input int n, input int err_at);
        for (int i = 0; i < n; i++) begin
            rx_valid = 1'b1;
            rx_data  = tx[i];
            rx_last  = (i == n - 1);
            rx_err   = (i == err_at);
            @(posedge clk); #1;
            if (i == err_at) break;
        end
        rx_valid = 1'b0;
        rx_last  = 1'b0;
        rx_err   = 1'b0;
        rx_data  = '0;
    endtask

    task automatic pkt(input string tag, input int n, input int err_at);
        int a0;
        int n0;
        bit e_ack;
        bit e_nak;
        a0 = ack_seen;
        n0 = nak_seen;
        e_ack = 1'b0;
        e_nak = 1'b0;
        if (m_phase != 0) begin
            e_nak = (err_at < 0);
        end else if (err_at >= 0 || n > MAX_PKT) begin
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end else begin
            e_ack   = 1'b1;
            m_phase = 1;
            m_len   = n;
            for (int i = 0; i < n; i++) mem[i] = tx[i];
        end
        send(n, err_at);
        @(posedge clk); #1;
        chk({tag, "_ack"}, ack_seen - a0, e_ack);
        chk({tag, "_nak"}, nak_seen - n0, e_nak);
        chk({tag, "_hasdata"}, buf_out_hasdata, m_phase == 1);
        chk({tag, "_drop"}, drop_cnt, m_drop);
        if (m_phase == 1) chk({tag, "_len"}, buf_out_len, m_len);
    endtask

    task automatic rd(input int idx);
        buf_out_addr = {2'($urandom_range(0, 3)), 9'(idx)};
        @(posedge clk); #1;
        chk("rd_q", buf_out_q, mem[idx]);
    endtask

    task automatic rd_some(input int k);
        rd(0);
        rd(m_len - 1);
        repeat (k) rd($urandom_range(0, m_len - 1));
    endtask

    task automatic release_buf(input bit pkt_in_ack, input bit pkt_in_rearm, input int extra);
        int a0;
        a0 = arm_ack_seen;
        buf_out_arm = 1'b1;
        @(posedge clk); #1;
        m_phase = 2;
        chk("rel_hasdata", buf_out_hasdata, 1'b0);
        chk("rel_arm_ack", buf_out_arm_ack, 1'b1);
        if (pkt_in_ack) begin
            fill_rand(1);
            pkt("nak_ack", 1, -1);
        end
        repeat (extra + 4) begin
            @(posedge clk); #1;
        end
        chk("rel_arm_ack_low", buf_out_arm_ack, 1'b0);
        chk("rel_ack_cycles", arm_ack_seen - a0, ACK_HOLD);
        if (pkt_in_rearm) begin
            fill_rand(3);
            pkt("nak_rearm", 3, -1);
        end
        buf_out_arm = 1'b0;
        @(posedge clk); #1;
        m_phase = 0;
    endtask

    initial begin
        #1 reset = 1'b1;
        #2;
        chk("rst_hasdata", buf_out_hasdata, 1'b0);
        chk("rst_len", buf_out_len, 10'd0);
        chk("rst_acks", {rx_ack, rx_nak, buf_out_arm_ack}, 3'b000);
        chk("rst_drop", drop_cnt, 8'd0);
        chk("rst_q", buf_out_q, 8'd0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        tx[0] = 8'h0A; tx[1] = 8'h11; tx[2] = 8'h22;
        pkt("p3", 3, -1);
        rd(1);
        rd(0);
        rd(2);
        release_buf(1'b0, 1'b0, 0);

        fill_rand(512);
        pkt("p512", 512, -1);
        rd_some(4);
        release_buf(1'b0, 1'b0, 0);
        fill_rand(515);
        pkt("p513", 513, -1);
        pkt("p515", 515, -1);
        fill_rand(2);
        pkt("p2", 2, -1);
        rd_some(0);
        release_buf(1'b0, 1'b0, 0);

        fill_rand(8);
        pkt("perr", 8, 4);
        tx[0] = 8'h00;
        pkt("p1", 1, -1);
        rd(0);

        fill_rand(5);
        pkt("nak_full", 5, -1);
        fill_rand(6);
        pkt("err_full", 6, 2);
        rd_some(0);
        release_buf(1'b1, 1'b1, 20);
        rd(0);

        fill_rand(37);
        pkt("p37", 37, -1);
        rd_some(3);
        release_buf(1'b0, 1'b1, 0);

        rx_err = 1'b1;
        repeat (260) begin
            @(posedge clk);
            m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        end
        #1 rx_err = 1'b0;
        @(posedge clk); #1;
        chk("drop_sat", drop_cnt, m_drop);

        fill_rand(10);
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1;
            rx_data  = tx[i];
            @(posedge clk); #1;
        end
        #2 reset = 1'b1;
        rx_valid = 1'b0;
        #1;
        chk("mid_rst_drop", drop_cnt, 8'd0);
        chk("mid_rst_hasdata", buf_out_hasdata, 1'b0);
        chk("mid_rst_len", buf_out_len, 10'd0);
        chk("mid_rst_q", buf_out_q, 8'd0);
        @(negedge clk) reset = 1'b0;
        m_phase = 0;
        m_drop  = 0;
        @(posedge clk); #1;
        fill_rand(9);
        pkt("post_rst", 9, -1);
        rd_some(2);

        chk("ack_nak_overlap", both_seen, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
